hazard_ctrl_mc: RTL
===================

Name: hazard_ctrl_mc

Overview:
- Parametrised, stateful successor to the single-cycle RV32I hazard unit.
- Generates per-stage enables and flushes (F/D/E/M), plus E-stage forwarding selects.
- Adds multi-cycle load-use stalls (configurable load latency), data-memory wait freezes, and mispredict flushes held pending across a freeze.
- Adds saturating stall and flush performance counters.
- Sits beside the 5-stage pipeline; all pipeline registers consume its enables and flushes.

Parameters:
- RA_W, 5, register-address width.
- LOAD_LAT, 1, load-use bubble cycles (1..7); 1 reproduces the classic single-bubble behaviour.
- CNT_W, 32, width of each performance counter.
- WB_LOAD, 2'd1, E_wb encoding that marks a load.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- D_rs1, D_rs2  in  RA_W  source registers of the D-stage instruction
- D_use_rs1, D_use_rs2  in  1  D instruction actually reads rs1/rs2
- E_rs1, E_rs2, E_rd  in  RA_W  E-stage register fields
- E_wb  in  2  E-stage writeback select
- branch_jump  in  1  E-stage instruction is a branch or jump
- mispre  in  1  E-stage prediction was wrong
- M_rd  in  RA_W;  M_wen_rf  in  1
- W_rd  in  RA_W;  W_wen_rf  in  1
- M_mem_wait  in  1  data memory not ready; M must hold
- F_en, D_en, E_en, M_en  out  1  stage register advance (1 = advance)
- D_flush, E_flush, W_flush  out  1  insert bubble into that stage register
- E_FWA, E_FWB  out  2  0 = register file, 1 = M, 2 = W
- cnt_stall  out  CNT_W  cycles with F_en = 0
- cnt_flush  out  CNT_W  mispredict flush events applied

Behaviour:
- Forwarding (combinational), per operand:
  - Select M (1) if M_rd == E_rsX, M_wen_rf = 1 and E_rsX != 0.
  - Else select W (2) under the same conditions on W.
  - Else 0.
  - Forwarding is independent of the FSM.
- Load-use detect, lu:
  - Requires E_wb == WB_LOAD and E_rd != 0.
  - Requires (D_use_rs1 and D_rs1 == E_rd) or (D_use_rs2 and D_rs2 == E_rd).
- FSM states: IDLE, LDSTALL, FLPEND. A 3-bit counter lcnt tracks load-stall bubbles.
- Priority each cycle: M_mem_wait > pending or new mispredict > load-use.
- M_mem_wait = 1 (any state):
  - F_en = D_en = E_en = M_en = 0 and W_flush = 1.
  - All other flushes are 0.
  - State and lcnt hold, except as below.
  - If mispre and branch_jump while in IDLE or LDSTALL, go to FLPEND.
- IDLE, no wait:
  - mispre and branch_jump: D_flush = E_flush = 1, all enables 1, cnt_flush += 1. Stay in IDLE; the load-use check is ignored this cycle.
  - Else lu: F_en = D_en = 0 and E_flush = 1. If LOAD_LAT > 1, go to LDSTALL with lcnt = LOAD_LAT-1; otherwise stay in IDLE.
  - Else all enables 1, no flushes.
- LDSTALL, no wait:
  - F_en = D_en = 0, E_flush = 1; lcnt decrements.
  - When lcnt reaches 1 this cycle, go to IDLE.
  - A mispredict cannot arise here: E holds a bubble.
- FLPEND, no wait:
  - Apply D_flush = E_flush = 1, all enables 1, cnt_flush += 1.
  - Clear lcnt and go to IDLE. A load stall in progress is cancelled.
- Counters:
  - cnt_stall increments on every cycle with F_en = 0, including wait cycles.
  - Both counters saturate at all-ones and never wrap.
- Reset (rst_n low, asynchronous):
  - State IDLE, lcnt 0, both counters 0.
  - Outputs while reset is asserted: all enables 1, all flushes 0, E_FWA = E_FWB = 0. The forwarding mux is forced to 0 during reset.
  - Reset during LDSTALL or FLPEND discards the stall or pending flush.

Test Plan:
- LOAD_LAT = 1; lw x5 in E, add x6,x5,x1 in D -> F_en = D_en = 0 and E_flush = 1 for exactly 1 cycle; next cycle all enables 1; cnt_stall = 1.
- LOAD_LAT = 3; same hazard -> 3 consecutive stall cycles, then IDLE; cnt_stall = 3. With D_use_rs1 = 0 and the match only on rs1 -> no stall.
- M_rd = W_rd = 7, both write enables set, E_rs1 = 7 -> E_FWA = 1. E_rs1 = 0 with the same M/W fields -> E_FWA = 0.
- mispre = branch_jump = 1 together with M_mem_wait = 1 for 2 cycles -> enables 0 and W_flush = 1 for 2 cycles, no D/E flush. When the wait drops, one cycle of D_flush = E_flush = 1; cnt_flush = 1.
- LOAD_LAT = 3; mispredict and lu in the same IDLE cycle -> flush only, no stall. Assert rst_n = 0 mid-LDSTALL -> enables 1 immediately and counters 0.
- Preload cnt_stall to all-ones via a long wait (CNT_W = 4) -> 20 stall cycles leave cnt_stall at 4'hF.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard controller for the 5-stage RV32I pipeline: stage enables/flushes,
// E-stage forwarding selects, load-use and memory-wait stalls, pending mispredict flushes.
`timescale 1ns/1ps
module hazard_ctrl_mc #(
  parameter int         RA_W     = 5,
  parameter int         LOAD_LAT = 1,
  parameter int         CNT_W    = 32,
  parameter logic [1:0] WB_LOAD  = 2'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  D_rs1,
  input  logic [RA_W-1:0]  D_rs2,
  input  logic             D_use_rs1,
  input  logic             D_use_rs2,
  input  logic [RA_W-1:0]  E_rs1,
  input  logic [RA_W-1:0]  E_rs2,
  input  logic [RA_W-1:0]  E_rd,
  input  logic [1:0]       E_wb,
  input  logic             branch_jump,
  input  logic             mispre,
  input  logic [RA_W-1:0]  M_rd,
  input  logic             M_wen_rf,
  input  logic [RA_W-1:0]  W_rd,
  input  logic             W_wen_rf,
  input  logic             M_mem_wait,
  output logic             F_en,
  output logic             D_en,
  output logic             E_en,
  output logic             M_en,
  output logic             D_flush,
  output logic             E_flush,
  output logic             W_flush,
  output logic [1:0]       E_FWA,
  output logic [1:0]       E_FWB,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LDSTALL = 2'd1,
    FLPEND  = 2'd2
  } state_t;

  localparam logic [2:0]       LCNT_INIT = 3'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [RA_W-1:0]  REG_ZERO  = {RA_W{1'b0}};

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] lcnt_r;
  logic [2:0] lcnt_nxt_s;

  logic [CNT_W-1:0] cnt_stall_r;
  logic [CNT_W-1:0] cnt_flush_r;

  logic       mis_s;
  logic       lu_s;
  logic       flush_evt_s;
  logic       f_en_s, d_en_s, e_en_s, m_en_s;
  logic       d_flush_s, e_flush_s, w_flush_s;
  logic [1:0] fwa_s, fwb_s;

  // M has the newer value, so it wins over W; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] mrd,
    input logic            mwen,
    input logic [RA_W-1:0] wrd,
    input logic            wwen
  );
    logic [1:0] sel;
    if (rs == REG_ZERO) begin
      sel = 2'd0;
    end else if (mwen && (mrd == rs)) begin
      sel = 2'd1;
    end else if (wwen && (wrd == rs)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  assign mis_s = mispre & branch_jump;
  assign lu_s  = (E_wb == WB_LOAD) && (E_rd != REG_ZERO) &&
                 ((D_use_rs1 && (D_rs1 == E_rd)) || (D_use_rs2 && (D_rs2 == E_rd)));

  // Forwarding selects, forced to the register file while in reset.
  always_comb begin
    fwa_s = 2'd0;
    fwb_s = 2'd0;
    if (rst_n) begin
      fwa_s = fwd_sel(E_rs1, M_rd, M_wen_rf, W_rd, W_wen_rf);
      fwb_s = fwd_sel(E_rs2, M_rd, M_wen_rf, W_rd, W_wen_rf);
    end else begin
      fwa_s = 2'd0;
      fwb_s = 2'd0;
    end
  end

  // Enable/flush decode and FSM next state; memory wait outranks everything.
  always_comb begin
    f_en_s      = 1'b1;
    d_en_s      = 1'b1;
    e_en_s      = 1'b1;
    m_en_s      = 1'b1;
    d_flush_s   = 1'b0;
    e_flush_s   = 1'b0;
    w_flush_s   = 1'b0;
    flush_evt_s = 1'b0;
    state_nxt_s = state_r;
    lcnt_nxt_s  = lcnt_r;
    if (!rst_n) begin
      state_nxt_s = IDLE;
      lcnt_nxt_s  = 3'd0;
    end else if (M_mem_wait) begin
      f_en_s    = 1'b0;
      d_en_s    = 1'b0;
      e_en_s    = 1'b0;
      m_en_s    = 1'b0;
      w_flush_s = 1'b1;
      if (mis_s && ((state_r == IDLE) || (state_r == LDSTALL))) begin
        state_nxt_s = FLPEND;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (mis_s) begin
            d_flush_s   = 1'b1;
            e_flush_s   = 1'b1;
            flush_evt_s = 1'b1;
          end else if (lu_s) begin
            f_en_s    = 1'b0;
            d_en_s    = 1'b0;
            e_flush_s = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt_s = LDSTALL;
              lcnt_nxt_s  = LCNT_INIT;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        LDSTALL: begin
          // E holds a bubble here, so no mispredict can be raised.
          f_en_s    = 1'b0;
          d_en_s    = 1'b0;
          e_flush_s = 1'b1;
          if (lcnt_r <= 3'd1) begin
            state_nxt_s = IDLE;
            lcnt_nxt_s  = 3'd0;
          end else begin
            lcnt_nxt_s  = lcnt_r - 3'd1;
          end
        end
        FLPEND: begin
          d_flush_s   = 1'b1;
          e_flush_s   = 1'b1;
          flush_evt_s = 1'b1;
          state_nxt_s = IDLE;
          lcnt_nxt_s  = 3'd0;
        end
        default: begin
          state_nxt_s = IDLE;
          lcnt_nxt_s  = 3'd0;
        end
      endcase
    end
  end

  // FSM state, bubble counter and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lcnt_r      <= 3'd0;
      cnt_stall_r <= {CNT_W{1'b0}};
      cnt_flush_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      lcnt_r  <= lcnt_nxt_s;
      if (!f_en_s && (cnt_stall_r != CNT_MAX)) begin
        cnt_stall_r <= cnt_stall_r + CNT_ONE;
      end else begin
        cnt_stall_r <= cnt_stall_r;
      end
      if (flush_evt_s && (cnt_flush_r != CNT_MAX)) begin
        cnt_flush_r <= cnt_flush_r + CNT_ONE;
      end else begin
        cnt_flush_r <= cnt_flush_r;
      end
    end
  end

  assign F_en      = f_en_s;
  assign D_en      = d_en_s;
  assign E_en      = e_en_s;
  assign M_en      = m_en_s;
  assign D_flush   = d_flush_s;
  assign E_flush   = e_flush_s;
  assign W_flush   = w_flush_s;
  assign E_FWA     = fwa_s;
  assign E_FWB     = fwb_s;
  assign cnt_stall = cnt_stall_r;
  assign cnt_flush = cnt_flush_r;

endmodule
